// File: rtl/serial_shift_unit_if.sv
// Request/response handshake bundle between the EX-stage pipeline and the serial shift unit.
// The pipeline side uses the master modport and the shift unit uses the slave modport.
interface serial_shift_unit_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [XLEN-1:0]    req_operand;
  logic [SHAMT_W-1:0] req_shamt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [XLEN-1:0]    rsp_result;

  modport master (
    output req_valid,
    input  req_ready,
    output req_op,
    output req_operand,
    output req_shamt,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_result
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_op,
    input  req_operand,
    input  req_shamt,
    output rsp_valid,
    input  rsp_ready,
    output rsp_result
  );
endinterface

// File: rtl/serial_shift_unit.sv
// Multi-cycle RV32I shift unit (SLL/SRL/SRA): moves the accumulator one bit per clock
// until the shift amount is consumed, then holds the result until the consumer takes it.
module serial_shift_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  serial_shift_unit_if.slave  bus,
  output logic                busy
);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [1:0]         op_q, op_d;

  // All outputs come from registered state only; nothing combinational from req_valid.
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StDone);
  assign bus.rsp_result = acc_q;
  assign busy           = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    op_d    = op_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            acc_d   = bus.req_operand;
            count_d = bus.req_shamt;
            op_d    = bus.req_op;
            // Zero shift and the reserved op pass the operand straight through.
            if ((bus.req_shamt == '0) || (bus.req_op == OpRsv)) begin
              state_d = StDone;
            end else begin
              state_d = StShift;
            end
          end
        end
        StShift: begin
          unique case (op_q)
            OpSll:   acc_d = {acc_q[XLEN-2:0], 1'b0};
            OpSrl:   acc_d = {1'b0, acc_q[XLEN-1:1]};
            OpSra:   acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_d = acc_q;
          endcase
          count_d = count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (bus.rsp_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit: shift results, latency, stalls, flush and async reset.
module tb_serial_shift_unit;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  int   checks;
  int   errors;

  serial_shift_unit_if #(.XLEN(32), .SHAMT_W(5)) bus ();

  serial_shift_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns in cycle 1 after the accept edge.
  task automatic accept(input logic [1:0] op, input logic [31:0] opnd, input logic [4:0] sh);
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_operand = opnd;
    bus.req_shamt   = sh;
    tick();
    bus.req_valid   = 1'b0;
    // Scramble the request fields: they must have no effect after the accept edge.
    bus.req_op      = ~op;
    bus.req_operand = ~opnd;
    bus.req_shamt   = ~sh;
  endtask

  // Cycle index (1-based after accept) of the first rsp_valid, 0 on timeout.
  task automatic wait_valid(output int lat);
    int k;
    lat = 0;
    k   = 1;
    while (k <= 40 && lat == 0) begin
      if (bus.rsp_valid) lat = k;
      else begin
        tick();
        k++;
      end
    end
  endtask

  // Full transaction with rsp_ready held high.
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] opnd,
                     input logic [4:0] sh, input logic [31:0] exp, input int exp_lat);
    int          k;
    int          lat;
    int          bc;
    logic        seen;
    logic [31:0] res;
    bus.rsp_ready = 1'b1;
    accept(op, opnd, sh);
    k    = 1;
    lat  = 0;
    bc   = 0;
    seen = 1'b0;
    res  = '0;
    while (k <= 40) begin
      if (busy) bc++;
      if (bus.rsp_valid && !seen) begin
        seen = 1'b1;
        lat  = k;
        res  = bus.rsp_result;
      end
      if (!busy) break;
      tick();
      k++;
    end
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int hits;
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    flush           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'b00;
    bus.req_operand = '0;
    bus.req_shamt   = '0;
    bus.rsp_ready   = 1'b0;

    #2;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'h0);
    #4 rst_n = 1'b1;
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    run("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32);
    run("sra4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 5);
    run("srl4", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 5);
    run("sll0", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
    run("rsv7", 2'b11, 32'h1234_5678, 5'd7, 32'h1234_5678, 1);

    // Consumer stall for three cycles after rsp_valid.
    bus.rsp_ready = 1'b0;
    accept(2'b01, 32'hF000_000F, 5'd8);
    wait_valid(lat);
    check("stall_latency", 32'(lat), 32'd9);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_result", bus.rsp_result, 32'h00F0_0000);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("hs_cycle_req_ready", 32'(bus.req_ready), 32'd0);
    check("hs_cycle_result", bus.rsp_result, 32'h00F0_0000);
    tick();
    check("after_hs_req_ready", 32'(bus.req_ready), 32'd1);
    check("after_hs_valid", 32'(bus.rsp_valid), 32'd0);

    // Flush five cycles after accept.
    accept(2'b00, 32'hFFFF_FFFF, 5'd20);
    repeat (4) tick();
    check("pre_flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_req_ready", 32'(bus.req_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.rsp_valid) hits++;
      tick();
    end
    check("flush_no_rsp", 32'(hits), 32'd0);

    // Flush coincident with a request in IDLE.
    bus.req_valid   = 1'b1;
    bus.req_op      = 2'b00;
    bus.req_operand = 32'hFFFF_FFFF;
    bus.req_shamt   = 5'd20;
    flush           = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    check("flush_idle_no_accept", 32'(busy), 32'd0);

    // Flush in DONE together with rsp_ready.
    bus.rsp_ready = 1'b0;
    accept(2'b00, 32'hFFFF_FFFF, 5'd20);
    wait_valid(lat);
    check("done_flush_latency", 32'(lat), 32'd21);
    check("done_flush_result", bus.rsp_result, 32'hFFF0_0000);
    bus.rsp_ready = 1'b1;
    flush         = 1'b1;
    tick();
    flush = 1'b0;
    check("done_flush_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_flush_busy", 32'(busy), 32'd0);

    // Asynchronous reset pulse mid-shift.
    accept(2'b00, 32'hFFFF_FFFF, 5'd20);
    repeat (2) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_result", bus.rsp_result, 32'h0);
    #1 rst_n = 1'b1;
    run("post_rst_sll1", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
